// File: rtl/inst_fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register, halt detection/drain
// and execution-time counters.
module inst_fetch_unit #(
  parameter logic [31:0] PC_STEP      = 32'd4,
  parameter logic [31:0] HALT_INST    = 32'hA800FFFF,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [31:0]      branch_addr,
  output logic [31:0]      imem_adrs,
  input  logic [31:0]      imem_inst,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_inst,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [31:0]        pc, pc_nxt;
  logic [31:0]        pc_inc;
  logic [31:0]        if_pc_nxt, if_inst_nxt;
  logic               halted_nxt;
  logic [CNT_W-1:0]   cycle_cnt_nxt, fetch_cnt_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_nxt;

  assign pc_inc    = pc + PC_STEP;
  assign imem_adrs = pc;

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pc        <= '0;
      if_pc     <= '0;
      if_inst   <= '0;
      halted    <= 1'b0;
      cycle_cnt <= '0;
      fetch_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      if_pc     <= if_pc_nxt;
      if_inst   <= if_inst_nxt;
      halted    <= halted_nxt;
      cycle_cnt <= cycle_cnt_nxt;
      fetch_cnt <= fetch_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next-state logic: branch beats freeze, everything holds by default
  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    if_pc_nxt     = if_pc;
    if_inst_nxt   = if_inst;
    halted_nxt    = halted;
    cycle_cnt_nxt = cycle_cnt;
    fetch_cnt_nxt = fetch_cnt;
    drain_cnt_nxt = drain_cnt;

    if (state != HALT) begin
      cycle_cnt_nxt = cycle_cnt + CNT_W'(1);
    end

    case (state)
      RUN: begin
        if (branch_taken) begin
          pc_nxt      = branch_addr;
          if_pc_nxt   = '0;
          if_inst_nxt = '0;
        end else if (!freeze) begin
          if_inst_nxt   = imem_inst;
          if_pc_nxt     = pc_inc;
          fetch_cnt_nxt = fetch_cnt + CNT_W'(1);
          if (imem_inst == HALT_INST) begin
            drain_cnt_nxt = '0;
            state_nxt     = DRAIN;
          end else begin
            pc_nxt = pc_inc;
          end
        end
      end
      DRAIN: begin
        // An older in-flight branch can still cancel the halt
        if (branch_taken) begin
          pc_nxt        = branch_addr;
          if_pc_nxt     = '0;
          if_inst_nxt   = '0;
          drain_cnt_nxt = '0;
          state_nxt     = RUN;
        end else if (!freeze) begin
          if_pc_nxt   = '0;
          if_inst_nxt = '0;
          if (drain_cnt == DRAIN_LAST) begin
            state_nxt  = HALT;
            halted_nxt = 1'b1;
          end else begin
            drain_cnt_nxt = drain_cnt + DRAIN_W'(1);
          end
        end
      end
      HALT: begin
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed self-checking bench for inst_fetch_unit with a combinational ROM model.
module tb_inst_fetch_unit;

  localparam logic [31:0] HALT = 32'hA800FFFF;
  localparam logic [31:0] FAR  = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst, freeze, branch_taken;
  logic [31:0] branch_addr, imem_adrs, imem_inst, if_pc, if_inst;
  logic        halted;
  logic [31:0] cycle_cnt, fetch_cnt;
  logic [31:0] halt_addr;

  int errors = 0;
  int checks = 0;

  inst_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_adrs    (imem_adrs),
    .imem_inst    (imem_inst),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .halted       (halted),
    .cycle_cnt    (cycle_cnt),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 ^ a;
  endfunction

  always_comb imem_inst = (imem_adrs == halt_addr) ? HALT : rom(imem_adrs);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (imem_adrs !== 32'd0) begin errors++; $display("FAIL rst_adrs: got %h want 0", imem_adrs); end
    checks++; if (if_inst !== 32'd0) begin errors++; $display("FAIL rst_inst: got %h want 0", if_inst); end
    checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted: got %b want 0", halted); end
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL rst_cycle: got %0d want 0", cycle_cnt); end
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL rst_fetch: got %0d want 0", fetch_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    tick();
    checks++; if (imem_adrs !== 32'd4) begin errors++; $display("FAIL seq1_adrs: got %h want 4", imem_adrs); end
    checks++; if (if_inst !== rom(32'd0)) begin errors++; $display("FAIL seq1_inst: got %h want %h", if_inst, rom(32'd0)); end
    checks++; if (if_pc !== 32'd4) begin errors++; $display("FAIL seq1_pc: got %h want 4", if_pc); end
    tick();
    checks++; if (imem_adrs !== 32'd8) begin errors++; $display("FAIL seq2_adrs: got %h want 8", imem_adrs); end
    checks++; if (if_inst !== rom(32'd4)) begin errors++; $display("FAIL seq2_inst: got %h want %h", if_inst, rom(32'd4)); end
    checks++; if (if_pc !== 32'd8) begin errors++; $display("FAIL seq2_pc: got %h want 8", if_pc); end
    checks++; if (fetch_cnt !== 32'd2) begin errors++; $display("FAIL seq2_fetch: got %0d want 2", fetch_cnt); end
    checks++; if (cycle_cnt !== 32'd2) begin errors++; $display("FAIL seq2_cycle: got %0d want 2", cycle_cnt); end
  endtask

  task automatic test_freeze();
    tick();
    tick();
    freeze = 1'b1;
    repeat (3) tick();
    checks++; if (imem_adrs !== 32'd16) begin errors++; $display("FAIL frz_adrs: got %h want 10", imem_adrs); end
    checks++; if (if_inst !== rom(32'd12)) begin errors++; $display("FAIL frz_inst: got %h want %h", if_inst, rom(32'd12)); end
    checks++; if (if_pc !== 32'd16) begin errors++; $display("FAIL frz_pc: got %h want 10", if_pc); end
    checks++; if (fetch_cnt !== 32'd4) begin errors++; $display("FAIL frz_fetch: got %0d want 4", fetch_cnt); end
    checks++; if (cycle_cnt !== 32'd7) begin errors++; $display("FAIL frz_cycle: got %0d want 7", cycle_cnt); end
    freeze = 1'b0;
    tick();
    checks++; if (imem_adrs !== 32'd20) begin errors++; $display("FAIL unfrz_adrs: got %h want 14", imem_adrs); end
    checks++; if (if_inst !== rom(32'd16)) begin errors++; $display("FAIL unfrz_inst: got %h want %h", if_inst, rom(32'd16)); end
    checks++; if (fetch_cnt !== 32'd5) begin errors++; $display("FAIL unfrz_fetch: got %0d want 5", fetch_cnt); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1;
    freeze       = 1'b1;
    branch_addr  = 32'h124;
    tick();
    checks++; if (imem_adrs !== 32'h124) begin errors++; $display("FAIL br_adrs: got %h want 124", imem_adrs); end
    checks++; if (if_inst !== 32'd0) begin errors++; $display("FAIL br_inst: got %h want 0", if_inst); end
    checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL br_pc: got %h want 0", if_pc); end
    checks++; if (fetch_cnt !== 32'd5) begin errors++; $display("FAIL br_fetch: got %0d want 5", fetch_cnt); end
    branch_taken = 1'b0;
    freeze       = 1'b0;
    tick();
    checks++; if (imem_adrs !== 32'h128) begin errors++; $display("FAIL br_next_adrs: got %h want 128", imem_adrs); end
    checks++; if (if_inst !== rom(32'h124)) begin errors++; $display("FAIL br_next_inst: got %h want %h", if_inst, rom(32'h124)); end
    checks++; if (if_pc !== 32'h128) begin errors++; $display("FAIL br_next_pc: got %h want 128", if_pc); end
    checks++; if (cycle_cnt !== 32'd10) begin errors++; $display("FAIL br_cycle: got %0d want 10", cycle_cnt); end
  endtask

  task automatic test_halt();
    halt_addr    = 32'd404;
    branch_taken = 1'b1;
    branch_addr  = 32'd396;
    tick();
    branch_taken = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (if_inst !== HALT) begin errors++; $display("FAIL halt_inst: got %h want %h", if_inst, HALT); end
    checks++; if (if_pc !== 32'd408) begin errors++; $display("FAIL halt_pc: got %0d want 408", if_pc); end
    checks++; if (imem_adrs !== 32'd404) begin errors++; $display("FAIL halt_adrs: got %0d want 404", imem_adrs); end
    checks++; if (fetch_cnt !== 32'd9) begin errors++; $display("FAIL halt_fetch: got %0d want 9", fetch_cnt); end
    checks++; if (cycle_cnt !== 32'd14) begin errors++; $display("FAIL halt_cycle: got %0d want 14", cycle_cnt); end
    repeat (3) tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL drain3_halted: got %b want 0", halted); end
    checks++; if (if_inst !== 32'd0) begin errors++; $display("FAIL drain3_inst: got %h want 0", if_inst); end
    checks++; if (imem_adrs !== 32'd404) begin errors++; $display("FAIL drain3_adrs: got %0d want 404", imem_adrs); end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL drain4_halted: got %b want 1", halted); end
    checks++; if (cycle_cnt !== 32'd18) begin errors++; $display("FAIL drain4_cycle: got %0d want 18", cycle_cnt); end
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    freeze       = 1'b1;
    repeat (10) tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL hold_halted: got %b want 1", halted); end
    checks++; if (cycle_cnt !== 32'd18) begin errors++; $display("FAIL hold_cycle: got %0d want 18", cycle_cnt); end
    checks++; if (fetch_cnt !== 32'd9) begin errors++; $display("FAIL hold_fetch: got %0d want 9", fetch_cnt); end
    checks++; if (imem_adrs !== 32'd404) begin errors++; $display("FAIL hold_adrs: got %0d want 404", imem_adrs); end
    branch_taken = 1'b0;
    freeze       = 1'b0;
  endtask

  task automatic test_drain_abort();
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    halt_addr = 32'd8;
    tick();
    tick();
    tick();
    checks++; if (if_inst !== HALT) begin errors++; $display("FAIL ab_inst: got %h want %h", if_inst, HALT); end
    checks++; if (if_pc !== 32'd12) begin errors++; $display("FAIL ab_pc: got %h want c", if_pc); end
    freeze = 1'b1;
    tick();
    checks++; if (if_inst !== HALT) begin errors++; $display("FAIL ab_frz_inst: got %h want %h", if_inst, HALT); end
    freeze = 1'b0;
    tick();
    checks++; if (if_inst !== 32'd0) begin errors++; $display("FAIL ab_bubble_inst: got %h want 0", if_inst); end
    checks++; if (imem_adrs !== 32'd8) begin errors++; $display("FAIL ab_bubble_adrs: got %h want 8", imem_adrs); end
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL ab_halted: got %b want 0", halted); end
    checks++; if (imem_adrs !== 32'h40) begin errors++; $display("FAIL ab_adrs: got %h want 40", imem_adrs); end
    branch_taken = 1'b0;
    halt_addr    = FAR;
    tick();
    checks++; if (imem_adrs !== 32'h44) begin errors++; $display("FAIL ab_resume_adrs: got %h want 44", imem_adrs); end
    checks++; if (if_inst !== rom(32'h40)) begin errors++; $display("FAIL ab_resume_inst: got %h want %h", if_inst, rom(32'h40)); end
    checks++; if (fetch_cnt !== 32'd4) begin errors++; $display("FAIL ab_fetch: got %0d want 4", fetch_cnt); end
    checks++; if (cycle_cnt !== 32'd7) begin errors++; $display("FAIL ab_cycle: got %0d want 7", cycle_cnt); end
    repeat (4) tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL ab_late_halted: got %b want 0", halted); end
    checks++; if (imem_adrs !== 32'h54) begin errors++; $display("FAIL ab_late_adrs: got %h want 54", imem_adrs); end
  endtask

  task automatic test_reset_drain_halt();
    halt_addr = 32'h5C;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    checks++; if (imem_adrs !== 32'd0) begin errors++; $display("FAIL rd_adrs: got %h want 0", imem_adrs); end
    checks++; if (if_inst !== 32'd0) begin errors++; $display("FAIL rd_inst: got %h want 0", if_inst); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rd_halted: got %b want 0", halted); end
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL rd_cycle: got %0d want 0", cycle_cnt); end
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL rd_fetch: got %0d want 0", fetch_cnt); end
    rst       = 1'b0;
    halt_addr = 32'd8;
    repeat (7) tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL rh_pre_halted: got %b want 1", halted); end
    checks++; if (fetch_cnt !== 32'd3) begin errors++; $display("FAIL rh_pre_fetch: got %0d want 3", fetch_cnt); end
    checks++; if (cycle_cnt !== 32'd7) begin errors++; $display("FAIL rh_pre_cycle: got %0d want 7", cycle_cnt); end
    rst = 1'b1;
    tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rh_halted: got %b want 0", halted); end
    checks++; if (imem_adrs !== 32'd0) begin errors++; $display("FAIL rh_adrs: got %h want 0", imem_adrs); end
    checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL rh_cycle: got %0d want 0", cycle_cnt); end
    checks++; if (fetch_cnt !== 32'd0) begin errors++; $display("FAIL rh_fetch: got %0d want 0", fetch_cnt); end
    checks++; if (if_inst !== 32'd0) begin errors++; $display("FAIL rh_inst: got %h want 0", if_inst); end
    rst       = 1'b0;
    halt_addr = FAR;
  endtask

  task automatic test_pc_wrap();
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    tick();
    checks++; if (imem_adrs !== 32'd0) begin errors++; $display("FAIL wrap_adrs: got %h want 0", imem_adrs); end
    checks++; if (if_pc !== 32'd0) begin errors++; $display("FAIL wrap_pc: got %h want 0", if_pc); end
    checks++; if (if_inst !== 32'hEFFF_FFFC) begin errors++; $display("FAIL wrap_inst: got %h want effffffc", if_inst); end
    checks++; if (fetch_cnt !== 32'd1) begin errors++; $display("FAIL wrap_fetch: got %0d want 1", fetch_cnt); end
    checks++; if (cycle_cnt !== 32'd2) begin errors++; $display("FAIL wrap_cycle: got %0d want 2", cycle_cnt); end
  endtask

  initial begin
    rst          = 1'b1;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'd0;
    halt_addr    = FAR;
    #1;
    test_reset();
    test_sequential();
    test_freeze();
    test_branch();
    test_halt();
    test_drain_abort();
    test_reset_drain_halt();
    test_pc_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
